// File: rtl/cordic_phase_sequencer.sv
// Phase-accumulator front end for the iterative CORDIC core: issues folded theta samples and flags result timing.
// Optional `CORDIC_SEQ_ABORT_EN` adds an abort input that ends a run early.
module cordic_phase_sequencer #(
   parameter int PHASE_W    = 16,
   parameter int CORDIC_LAT = 16,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [PHASE_W-1:0] phase_start,
   input  logic [PHASE_W-1:0] phase_inc,
   input  logic [CNT_W-1:0]   num_samples,
`ifdef CORDIC_SEQ_ABORT_EN
   input  logic               abort,
`endif
   output logic [PHASE_W-1:0] theta,
   output logic               theta_valid,
   output logic               cos_neg,
   output logic               res_valid,
   output logic               busy,
   output logic               done
);

   localparam int LAT_W = (CORDIC_LAT > 1) ? $clog2(CORDIC_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CORDIC_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t             state_q, state_d;
   logic [PHASE_W-1:0] acc_q, acc_d;
   logic [PHASE_W-1:0] inc_q, inc_d;
   logic [CNT_W-1:0]   num_q, num_d;
   logic [CNT_W-1:0]   issued_q, issued_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic [PHASE_W-1:0] theta_q, theta_d;
   logic               cos_neg_q, cos_neg_d;
   logic               theta_valid_q, theta_valid_d;
   logic               res_valid_q, res_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               abort_req;
   logic [PHASE_W-1:0] next_phase;

`ifdef CORDIC_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Quadrants 1 and 2 are reflected about 90 deg into [-90,+90]; cosine then changes sign.
   function automatic logic [PHASE_W:0] fold(input logic [PHASE_W-1:0] p);
      logic [PHASE_W-1:0] half;
      logic [1:0]         quad;
      half = {1'b1, {(PHASE_W-1){1'b0}}};
      quad = p[PHASE_W-1 -: 2];
      if (quad == 2'b01 || quad == 2'b10)
         return {1'b1, half - p};
      else
         return {1'b0, p};
   endfunction

   assign next_phase = acc_q + inc_q;

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      inc_d         = inc_q;
      num_d         = num_q;
      issued_d      = issued_q;
      lat_d         = lat_q;
      theta_d       = theta_q;
      cos_neg_d     = cos_neg_q;
      busy_d        = busy_q;
      theta_valid_d = 1'b0;
      res_valid_d   = 1'b0;
      done_d        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d  = phase_start;
               inc_d  = phase_inc;
               num_d  = num_samples;
               busy_d = 1'b1;
               if (num_samples == '0) begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d                = S_ISSUE;
                  theta_valid_d          = 1'b1;
                  {cos_neg_d, theta_d}   = fold(phase_start);
                  issued_d               = CNT_W'(1);
               end
            end
         end
         S_ISSUE: begin
            if (abort_req) begin
               state_d = S_FINISH;
               done_d  = 1'b1;
            end else begin
               state_d     = S_WAIT;
               lat_d       = LAT_LOAD;
               res_valid_d = (CORDIC_LAT == 1);
            end
         end
         S_WAIT: begin
            if (abort_req) begin
               state_d = S_FINISH;
               done_d  = 1'b1;
            end else if (lat_q == '0) begin
               if (issued_q == num_q) begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d              = S_ISSUE;
                  acc_d                = next_phase;
                  {cos_neg_d, theta_d} = fold(next_phase);
                  theta_valid_d        = 1'b1;
                  issued_d             = issued_q + CNT_W'(1);
               end
            end else begin
               lat_d       = lat_q - LAT_W'(1);
               // res_valid is registered, so it is raised one cycle ahead of the counter hitting zero.
               res_valid_d = (lat_q == LAT_W'(1));
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         acc_q         <= '0;
         inc_q         <= '0;
         num_q         <= '0;
         issued_q      <= '0;
         lat_q         <= '0;
         theta_q       <= '0;
         cos_neg_q     <= 1'b0;
         theta_valid_q <= 1'b0;
         res_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         inc_q         <= inc_d;
         num_q         <= num_d;
         issued_q      <= issued_d;
         lat_q         <= lat_d;
         theta_q       <= theta_d;
         cos_neg_q     <= cos_neg_d;
         theta_valid_q <= theta_valid_d;
         res_valid_q   <= res_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign theta       = theta_q;
   assign cos_neg     = cos_neg_q;
   assign theta_valid = theta_valid_q;
   assign res_valid   = res_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Self-checking bench for cordic_phase_sequencer: table vectors, corner sequences and random runs vs a cycle-timeline model.
module tb_cordic_phase_sequencer;

   localparam int LAT = 16;
   localparam int PER = LAT + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] phase_start;
   logic [15:0] phase_inc;
   logic [15:0] num_samples;
   logic        abort;
   logic [15:0] theta;
   logic        theta_valid;
   logic        cos_neg;
   logic        res_valid;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] prev_th = '0;
   logic        prev_cn = 1'b0;
   logic [15:0] tv_thetas[$];
   int          rv_count;

   always #5 clk = ~clk;

   cordic_phase_sequencer #(
      .PHASE_W   (16),
      .CORDIC_LAT(LAT),
      .CNT_W     (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .phase_start(phase_start),
      .phase_inc  (phase_inc),
      .num_samples(num_samples),
`ifdef CORDIC_SEQ_ABORT_EN
      .abort      (abort),
`endif
      .theta      (theta),
      .theta_valid(theta_valid),
      .cos_neg    (cos_neg),
      .res_valid  (res_valid),
      .busy       (busy),
      .done       (done)
   );

   // Angles in [90deg, 270deg) are reflected about 90deg; returns {cos_neg, theta}.
   function automatic logic [16:0] fold_ref(input logic [15:0] p);
      if (p >= 16'h4000 && p < 16'hC000)
         return {1'b1, 16'(17'h08000 - 17'(p))};
      else
         return {1'b0, p};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle c=0 drives start; cycle c>=1 is the c-th cycle after the start edge.
   task automatic run(input logic [15:0] ps, input logic [15:0] inc, input int n,
                      input int extra_start, input int abort_cyc, input int reset_cyc);
      int total, last_act, k;
      logic        e_tv, e_rv, e_done, e_busy, e_cn;
      logic [15:0] e_th, p;
      logic [16:0] f;
      last_act = PER * n;
      total    = (n == 0) ? 1 : last_act + 1;
      if (abort_cyc > 0 && abort_cyc <= last_act) begin
         last_act = abort_cyc;
         total    = abort_cyc + 1;
      end
      e_th = prev_th;
      e_cn = prev_cn;
      tv_thetas.delete();
      rv_count = 0;
      for (int c = 0; c <= total + 1; c++) begin
         @(negedge clk);
         if (c > 0) begin
            if (reset_cyc > 0 && c == reset_cyc + 1) begin
               chk("rst_theta", int'(theta), 0);
               chk("rst_cos_neg", int'(cos_neg), 0);
               chk("rst_theta_valid", int'(theta_valid), 0);
               chk("rst_res_valid", int'(res_valid), 0);
               chk("rst_busy", int'(busy), 0);
               chk("rst_done", int'(done), 0);
               prev_th = '0;
               prev_cn = 1'b0;
               reset   = 1'b0;
               start   = 1'b0;
               abort   = 1'b0;
               return;
            end
            e_tv   = (n != 0) && (c <= last_act) && ((c - 1) % PER == 0);
            e_rv   = (n != 0) && (c <= last_act) && (c % PER == 0);
            e_done = (c == total);
            e_busy = (c <= total);
            if (n != 0) begin
               k = (c - 1) / PER;
               if (k > (last_act - 1) / PER) k = (last_act - 1) / PER;
               p = 16'(32'(ps) + k * 32'(inc));
               f = fold_ref(p);
               e_cn = f[16];
               e_th = f[15:0];
            end
            chk("theta_valid", int'(theta_valid), int'(e_tv));
            chk("res_valid", int'(res_valid), int'(e_rv));
            chk("done", int'(done), int'(e_done));
            chk("busy", int'(busy), int'(e_busy));
            chk("theta", int'(theta), int'(e_th));
            chk("cos_neg", int'(cos_neg), int'(e_cn));
            if (theta_valid) tv_thetas.push_back(theta);
            if (res_valid) rv_count++;
         end
         start = (c == 0) || (c == extra_start);
         if (c == 0) begin
            phase_start = ps;
            phase_inc   = inc;
            num_samples = 16'(n);
         end else begin
            phase_start = ~ps;
            phase_inc   = ~inc;
            num_samples = 16'(n + 3);
         end
         abort = (c > 0) && (c == abort_cyc);
         reset = (c > 0) && (c == reset_cyc);
      end
      start   = 1'b0;
      abort   = 1'b0;
      prev_th = e_th;
      prev_cn = e_cn;
   endtask

   typedef struct {
      logic [15:0] ps;
      logic [15:0] exp_theta;
      logic        exp_cos;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{16'h1555, 16'h1555, 1'b0};
      vecs[1] = '{16'h6000, 16'h2000, 1'b1};
      vecs[2] = '{16'hA000, 16'hE000, 1'b1};
      vecs[3] = '{16'hC000, 16'hC000, 1'b0};
      vecs[4] = '{16'h4000, 16'h4000, 1'b1};
      vecs[5] = '{16'h8000, 16'h0000, 1'b1};
      vecs[6] = '{16'hBFFF, 16'hC001, 1'b1};
      vecs[7] = '{16'h3FFF, 16'h3FFF, 1'b0};

      reset = 1'b1; start = 1'b0; abort = 1'b0;
      phase_start = '0; phase_inc = '0; num_samples = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_theta", int'(theta), 0);
      chk("reset_theta_valid", int'(theta_valid), 0);
      chk("reset_res_valid", int'(res_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_cos_neg", int'(cos_neg), 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run(vecs[i].ps, 16'h0000, 1, 0, 0, 0);
         chk("vec_theta", int'(theta), int'(vecs[i].exp_theta));
         chk("vec_cos_neg", int'(cos_neg), int'(vecs[i].exp_cos));
         chk("vec_tv_count", tv_thetas.size(), 1);
         chk("vec_rv_count", rv_count, 1);
      end

      run(16'hF000, 16'h2000, 3, 0, 0, 0);
      chk("wrap_tv_count", tv_thetas.size(), 3);
      chk("wrap_rv_count", rv_count, 3);
      if (tv_thetas.size() == 3) begin
         chk("wrap_theta0", int'(tv_thetas[0]), 16'hF000);
         chk("wrap_theta1", int'(tv_thetas[1]), 16'h1000);
         chk("wrap_theta2", int'(tv_thetas[2]), 16'h3000);
      end

      run(16'h1234, 16'h0100, 0, 0, 0, 0);
      chk("zero_tv_count", tv_thetas.size(), 0);
      chk("zero_rv_count", rv_count, 0);

      run(16'h0800, 16'h1000, 4, 30, 0, 0);
      chk("restart_tv_count", tv_thetas.size(), 4);
      chk("restart_rv_count", rv_count, 4);

      run(16'h2000, 16'h0400, 4, 0, 0, PER + 1 + 5);
      run(16'h7000, 16'h0010, 2, 0, 0, 0);
      chk("after_rst_tv_count", tv_thetas.size(), 2);

`ifdef CORDIC_SEQ_ABORT_EN
      run(16'h0100, 16'h0100, 5, 0, 5, 0);
      chk("abort_tv_count", tv_thetas.size(), 1);
      chk("abort_rv_count", rv_count, 0);
`endif

      for (int r = 0; r < 8; r++) begin
         run(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(2, 40)), 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
